// File: rtl/jump_charger_if.sv
// Player-side signal bundle for jump_charger: button/game controls in, distance and status out.
interface jump_charger_if #(
    parameter int unsigned DIST_W = 8
) ();
    logic              btn;
    logic              restart;
    logic              jump_done;
    logic [DIST_W-1:0] jump_dist;
    logic              charging;
    logic [DIST_W-1:0] charge_level;
    logic              busy;

    modport master (
        output btn, restart, jump_done,
        input  jump_dist, charging, charge_level, busy
    );

    modport slave (
        input  btn, restart, jump_done,
        output jump_dist, charging, charge_level, busy
    );
endinterface

// File: rtl/jump_charger.sv
// Jump button front end: debounces the button, charges a distance while held, emits it as a held pulse.
// Optional JUMP_CHARGER_PINGPONG_EN: charge level bounces between MIN_DIST and MAX_DIST instead of saturating.
module jump_charger #(
    parameter int unsigned DIST_W          = 8,
    parameter int unsigned TICK_DIV        = 2000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 4000000,
    parameter int unsigned MIN_DIST        = 1,
    parameter int unsigned MAX_DIST        = 25
) (
    input  logic           clk,
    input  logic           clr,
    jump_charger_if.slave  io
);
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHARGE,
        ST_EMIT,
        ST_LOCK
    } state_t;

    state_t             state;
    logic               btn_meta;
    logic               btn_s;
    logic               armed;
    logic [PRE_W-1:0]   prescaler;
    logic [DEB_W-1:0]   deb_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DIST_W-1:0]  level_q;
    logic [DIST_W-1:0]  level_nxt;
    logic [DIST_W-1:0]  jump_dist_q;
    logic               charging_q;
    logic               busy_q;
    logic               tick;
    logic               deb_done;
    logic               hold_done;

    assign tick      = (prescaler == PRE_W'(TICK_DIV - 1));
    assign deb_done  = (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (!clr) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= io.btn;
            btn_s    <= btn_meta;
        end
    end

`ifdef JUMP_CHARGER_PINGPONG_EN
    logic dir;
    logic dir_nxt;

    // Bounce: dir=0 counts up toward MAX_DIST, dir=1 counts down toward MIN_DIST
    always_comb begin
        dir_nxt   = dir;
        level_nxt = level_q;
        if (!dir) begin
            level_nxt = level_q + DIST_W'(1);
            if (level_nxt >= DIST_W'(MAX_DIST)) dir_nxt = 1'b1;
        end else begin
            level_nxt = level_q - DIST_W'(1);
            if (level_nxt <= DIST_W'(MIN_DIST)) dir_nxt = 1'b0;
        end
    end
`else
    always_comb begin
        level_nxt = (level_q >= DIST_W'(MAX_DIST)) ? level_q : level_q + DIST_W'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!clr || io.restart) begin
            state       <= ST_IDLE;
            armed       <= 1'b0;
            prescaler   <= '0;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            level_q     <= '0;
            jump_dist_q <= '0;
            charging_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef JUMP_CHARGER_PINGPONG_EN
            dir         <= 1'b0;
`endif
        end else begin
            case (state)
                // Only an armed IDLE (button seen released) may start a charge
                ST_IDLE: begin
                    if (!btn_s) begin
                        armed   <= 1'b1;
                        deb_cnt <= '0;
                    end else if (armed) begin
                        if (deb_done) begin
                            state      <= ST_CHARGE;
                            charging_q <= 1'b1;
                            level_q    <= '0;
                            prescaler  <= '0;
                            deb_cnt    <= '0;
`ifdef JUMP_CHARGER_PINGPONG_EN
                            dir        <= 1'b0;
`endif
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end
                end
                ST_CHARGE: begin
                    if (btn_s) begin
                        deb_cnt <= '0;
                        if (tick) begin
                            prescaler <= '0;
                            level_q   <= level_nxt;
`ifdef JUMP_CHARGER_PINGPONG_EN
                            dir       <= dir_nxt;
`endif
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end else if (deb_done) begin
                        deb_cnt    <= '0;
                        charging_q <= 1'b0;
                        if (level_q < DIST_W'(MIN_DIST)) begin
                            state <= ST_IDLE;
                        end else begin
                            state       <= ST_EMIT;
                            busy_q      <= 1'b1;
                            jump_dist_q <= level_q;
                            hold_cnt    <= '0;
                        end
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (hold_done) begin
                        jump_dist_q <= '0;
                        state       <= ST_LOCK;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_LOCK: begin
                    if (io.jump_done) begin
                        state   <= ST_IDLE;
                        level_q <= '0;
                        armed   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign io.jump_dist    = jump_dist_q;
    assign io.charging     = charging_q;
    assign io.charge_level = level_q;
    assign io.busy         = busy_q;
endmodule

// File: tb/tb_jump_charger.sv
// Directed bench for jump_charger: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_jump_charger;
    localparam int unsigned DW = 8;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int HC = 8;
    localparam int MN = 1;
    localparam int MX = 25;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    jump_charger_if #(.DIST_W(DW)) io ();

    jump_charger #(
        .DIST_W(DW), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HC), .MIN_DIST(MN), .MAX_DIST(MX)
    ) dut (
        .clk(clk),
        .clr(clr),
        .io (io.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 charge, 2 emit, 3 lock; level derived from held cycles
    int m_mode = 0, m_hi = 0, m_run = 0, m_left = 0, m_lvl = 0;
    bit m_armed = 0, m_s1 = 0, m_s2 = 0, m_bs;
    int exp_dist = 0, exp_lvl = 0;
    bit exp_chg = 0, exp_busy = 0;

    always @(posedge clk) begin
        m_bs = m_s2;
        if (!clr) begin
            m_s1 = 0;
            m_s2 = 0;
        end else begin
            m_s2 = m_s1;
            m_s1 = io.btn;
        end
        m_lvl = (m_hi / TD > MX) ? MX : m_hi / TD;
        if (!clr || io.restart) begin
            m_mode = 0; m_hi = 0; m_run = 0; m_left = 0; m_armed = 0;
        end else begin
            case (m_mode)
                0: if (!m_bs) begin
                       m_armed = 1; m_run = 0;
                   end else if (m_armed) begin
                       m_run++;
                       if (m_run == DB) begin m_mode = 1; m_hi = 0; m_run = 0; end
                   end
                1: if (m_bs) begin
                       m_run = 0; m_hi++;
                   end else begin
                       m_run++;
                       if (m_run == DB) begin
                           m_run = 0;
                           if (m_lvl < MN) m_mode = 0;
                           else begin m_mode = 2; m_left = HC; end
                       end
                   end
                2: begin
                       m_left--;
                       if (m_left == 0) m_mode = 3;
                   end
                default: if (io.jump_done) begin m_mode = 0; m_hi = 0; m_armed = 0; end
            endcase
        end
        m_lvl    = (m_hi / TD > MX) ? MX : m_hi / TD;
        exp_lvl  = m_lvl;
        exp_chg  = (m_mode == 1);
        exp_busy = (m_mode >= 2);
        exp_dist = (m_mode == 2) ? m_lvl : 0;
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_jump_dist", 32'(io.jump_dist), exp_dist);
            check("cyc_charge_level", 32'(io.charge_level), exp_lvl);
            check("cyc_charging", 32'(io.charging), int'(exp_chg));
            check("cyc_busy", 32'(io.busy), int'(exp_busy));
        end
    end

    // Emission monitor: cumulative counts, tests take baselines
    int nz_cnt = 0, busy_cnt = 0, last_dist = 0;
    always @(negedge clk) begin
        if (io.jump_dist != '0) begin
            nz_cnt++;
            last_dist = int'(io.jump_dist);
        end
        if (io.busy === 1'b1) busy_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for(input int sel, input string name);
        int n = 0;
        while (((sel == 0) ? io.charging : io.busy) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, required signal high", name, n);
        end
    endtask

    task automatic pulse_done();
        io.jump_done = 1'b1;
        cyc(1);
        io.jump_done = 1'b0;
    endtask

    int nz0, bz0;

    initial begin
        clr = 1'b0;
        io.btn = 1'b0;
        io.restart = 1'b0;
        io.jump_done = 1'b0;
        cyc(1);
        chk_en = 1;
        cyc(2);
        check("rst_jump_dist", 32'(io.jump_dist), 0);
        check("rst_charge_level", 32'(io.charge_level), 0);
        check("rst_busy", 32'(io.busy), 0);
        check("rst_charging", 32'(io.charging), 0);
        clr = 1'b1;
        cyc(4);

        // 1: 72 held cycles -> 18
        nz0 = nz_cnt;
        io.btn = 1'b1;
        wait_for(0, "t1_charge");
        cyc(70);
        io.btn = 1'b0;
        wait_for(1, "t1_busy");
        check("t1_level", 32'(io.charge_level), 18);
        check("t1_dist_first", 32'(io.jump_dist), 18);
        cyc(12);
        check("t1_hold_len", 32'(nz_cnt - nz0), 8);
        check("t1_last_dist", 32'(last_dist), 18);
        check("t1_busy_lock", 32'(io.busy), 1);
        pulse_done();
        check("t1_busy_free", 32'(io.busy), 0);
        cyc(4);

        // 2: long hold saturates
        nz0 = nz_cnt;
        io.btn = 1'b1;
        wait_for(0, "t2_charge");
        cyc(200 * TD);
        io.btn = 1'b0;
        wait_for(1, "t2_busy");
        cyc(12);
        check("t2_last_dist", 32'(last_dist), 25);
        check("t2_hold_len", 32'(nz_cnt - nz0), 8);
        pulse_done();
        cyc(4);

        // 3: tap produces no jump
        nz0 = nz_cnt;
        bz0 = busy_cnt;
        io.btn = 1'b1;
        wait_for(0, "t3_charge");
        io.btn = 1'b0;
        cyc(10);
        check("t3_charging", 32'(io.charging), 0);
        check("t3_level", 32'(io.charge_level), 0);
        check("t3_no_dist", 32'(nz_cnt - nz0), 0);
        check("t3_no_busy", 32'(busy_cnt - bz0), 0);

        // 4: glitch rejected at level 7, then held button across LOCK
        io.btn = 1'b1;
        wait_for(0, "t4_charge");
        cyc(26);
        io.btn = 1'b0;
        cyc(2);
        io.btn = 1'b1;
        cyc(2);
        check("t4_glitch_charging", 32'(io.charging), 1);
        check("t4_glitch_level", 32'(io.charge_level), 7);
        cyc(10);
        io.btn = 1'b0;
        wait_for(1, "t4_busy");
        io.btn = 1'b1;
        cyc(12);
        check("t4_last_dist", 32'(last_dist), 10);
        pulse_done();
        cyc(20);
        check("t4_no_autocharge", 32'(io.charging), 0);
        check("t4_idle_busy", 32'(io.busy), 0);
        io.btn = 1'b0;
        cyc(1);
        io.btn = 1'b1;
        wait_for(0, "t4_recharge");
        io.btn = 1'b0;
        cyc(10);

        // 5: restart mid-charge at level 10
        nz0 = nz_cnt;
        bz0 = busy_cnt;
        io.btn = 1'b1;
        wait_for(0, "t5_charge");
        cyc(40);
        check("t5_level", 32'(io.charge_level), 10);
        io.restart = 1'b1;
        cyc(1);
        io.restart = 1'b0;
        check("t5_charging", 32'(io.charging), 0);
        check("t5_level_clr", 32'(io.charge_level), 0);
        check("t5_dist", 32'(io.jump_dist), 0);
        io.btn = 1'b0;
        cyc(12);
        check("t5_no_emit", 32'(nz_cnt - nz0), 0);
        check("t5_no_busy", 32'(busy_cnt - bz0), 0);

        // 6: clr mid-EMIT at 14, then jump_done only during EMIT
        io.btn = 1'b1;
        wait_for(0, "t6_charge");
        cyc(54);
        io.btn = 1'b0;
        wait_for(1, "t6_busy");
        cyc(2);
        check("t6_dist", 32'(io.jump_dist), 14);
        clr = 1'b0;
        cyc(1);
        clr = 1'b1;
        check("t6_clr_dist", 32'(io.jump_dist), 0);
        check("t6_clr_busy", 32'(io.busy), 0);
        cyc(4);
        io.btn = 1'b1;
        wait_for(0, "t6_charge2");
        cyc(6);
        io.btn = 1'b0;
        wait_for(1, "t6_busy2");
        check("t6_dist2", 32'(io.jump_dist), 2);
        io.jump_done = 1'b1;
        cyc(3);
        io.jump_done = 1'b0;
        cyc(12);
        check("t6_lock_held", 32'(io.busy), 1);
        check("t6_lock_dist", 32'(io.jump_dist), 0);
        pulse_done();
        check("t6_lock_free", 32'(io.busy), 0);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
